// File: rtl/pwm_fade_sequencer_if.sv
// Control/config and PWM-core signal bundle for pwm_fade_sequencer.
// master = LED control + PWM core side, slave = the sequencer.
interface pwm_fade_sequencer_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] cfg_period;
    logic [WIDTH-1:0] cfg_min;
    logic [WIDTH-1:0] cfg_max;
    logic [WIDTH-1:0] cfg_step;
    logic [CNT_W-1:0] cfg_div;
    logic [CNT_W-1:0] cfg_hold;
    logic             pwm_period_end;
    logic [WIDTH-1:0] duty_cycle;
    logic [WIDTH-1:0] period;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, cfg_period, cfg_min, cfg_max,
        output cfg_step, cfg_div, cfg_hold, pwm_period_end,
        input  duty_cycle, period, busy, done
    );

    modport slave (
        input  start, abort, cfg_period, cfg_min, cfg_max,
        input  cfg_step, cfg_div, cfg_hold, pwm_period_end,
        output duty_cycle, period, busy, done
    );
endinterface

// File: rtl/pwm_fade_sequencer.sv
// Breathing-profile sequencer driving a PWM core's duty/period at period boundaries.
// Define PWM_FADE_LOOP_EN to repeat the profile until abort instead of single-shot.
module pwm_fade_sequencer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    pwm_fade_sequencer_if.slave  sif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RAMP_UP,
        S_HOLD_HI,
        S_RAMP_DN,
        S_HOLD_LO
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_duty;
    logic [WIDTH-1:0] w_duty_nxt;
    logic [WIDTH-1:0] r_period;
    logic [WIDTH-1:0] r_min;
    logic [WIDTH-1:0] r_max;
    logic [WIDTH-1:0] r_step;
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_hold;
    logic [CNT_W-1:0] r_div_cnt;
    logic [CNT_W-1:0] w_div_cnt_nxt;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [CNT_W-1:0] w_hold_cnt_nxt;
    logic             r_busy;
    logic             r_done;
    logic             w_done_nxt;
    logic             w_fin;
    logic             w_load;
    logic             w_tick;
    logic             w_up_sat;
    logic             w_hold_last;
    logic             w_hold_nz;
    logic [WIDTH-1:0] w_cfg_max;
    logic [WIDTH-1:0] w_cfg_min;
    logic [WIDTH-1:0] w_dn_val;
    logic [WIDTH:0]   w_up_sum;
    logic [WIDTH:0]   w_dn_floor;
    logic [CNT_W:0]   w_div_inc;
    logic [CNT_W:0]   w_hold_inc;

    // Peak can never exceed the period, floor never exceeds the peak.
    assign w_cfg_max = (sif.cfg_max < sif.cfg_period) ?
                       sif.cfg_max : sif.cfg_period;
    assign w_cfg_min = (sif.cfg_min < w_cfg_max) ?
                       sif.cfg_min : w_cfg_max;

    assign w_load = (r_state == S_IDLE) && sif.start && !sif.abort;

    assign w_div_inc   = {1'b0, r_div_cnt} + 1'b1;
    assign w_tick      = (r_state != S_IDLE) && sif.pwm_period_end &&
                         (w_div_inc >= {1'b0, r_div});
    assign w_hold_inc  = {1'b0, r_hold_cnt} + 1'b1;
    assign w_hold_last = w_hold_inc >= {1'b0, r_hold};
    assign w_hold_nz   = r_hold != '0;

    assign w_up_sum   = {1'b0, r_duty} + {1'b0, r_step};
    assign w_up_sat   = w_up_sum >= {1'b0, r_max};
    assign w_dn_floor = {1'b0, r_min} + {1'b0, r_step};
    assign w_dn_val   = ({1'b0, r_duty} >= w_dn_floor) ?
                        (r_duty - r_step) : r_min;

    always_comb begin
        w_state_nxt    = r_state;
        w_duty_nxt     = r_duty;
        w_div_cnt_nxt  = r_div_cnt;
        w_hold_cnt_nxt = r_hold_cnt;
        w_done_nxt     = 1'b0;
        w_fin          = 1'b0;

        if (sif.pwm_period_end && (r_state != S_IDLE))
            w_div_cnt_nxt = w_tick ? '0 : w_div_inc[CNT_W-1:0];

        unique case (r_state)
            S_IDLE: begin
                if (w_load) begin
                    w_duty_nxt  = w_cfg_min;
                    w_state_nxt = S_RAMP_UP;
                end
            end
            S_RAMP_UP: begin
                if (w_tick) begin
                    if (w_up_sat) begin
                        w_duty_nxt  = r_max;
                        w_state_nxt = w_hold_nz ? S_HOLD_HI : S_RAMP_DN;
                    end else begin
                        w_duty_nxt = w_up_sum[WIDTH-1:0];
                    end
                end
            end
            S_HOLD_HI: begin
                if (w_tick) begin
                    if (w_hold_last)
                        w_state_nxt = S_RAMP_DN;
                    else
                        w_hold_cnt_nxt = w_hold_inc[CNT_W-1:0];
                end
            end
            S_RAMP_DN: begin
                if (w_tick) begin
                    w_duty_nxt = w_dn_val;
                    if (w_dn_val == r_min) begin
                        if (w_hold_nz)
                            w_state_nxt = S_HOLD_LO;
                        else
                            w_fin = 1'b1;
                    end
                end
            end
            S_HOLD_LO: begin
                if (w_tick) begin
                    if (w_hold_last)
                        w_fin = 1'b1;
                    else
                        w_hold_cnt_nxt = w_hold_inc[CNT_W-1:0];
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_fin) begin
            w_done_nxt = 1'b1;
            w_duty_nxt = r_min;
`ifdef PWM_FADE_LOOP_EN
            w_state_nxt = S_RAMP_UP;
`else
            w_state_nxt = S_IDLE;
`endif
        end

        // Every state entry restarts both the divider and dwell count.
        if (w_state_nxt != r_state) begin
            w_div_cnt_nxt  = '0;
            w_hold_cnt_nxt = '0;
        end

        if (sif.abort) begin
            w_state_nxt    = S_IDLE;
            w_duty_nxt     = '0;
            w_done_nxt     = 1'b0;
            w_div_cnt_nxt  = '0;
            w_hold_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_duty     <= '0;
            r_div_cnt  <= '0;
            r_hold_cnt <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_duty     <= w_duty_nxt;
            r_div_cnt  <= w_div_cnt_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_busy     <= (w_state_nxt != S_IDLE);
            r_done     <= w_done_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_period <= '0;
            r_min    <= '0;
            r_max    <= '0;
            r_step   <= '0;
            r_div    <= '0;
            r_hold   <= '0;
        end else if (w_load) begin
            r_period <= sif.cfg_period;
            r_min    <= w_cfg_min;
            r_max    <= w_cfg_max;
            r_step   <= (sif.cfg_step == '0) ? WIDTH'(1) : sif.cfg_step;
            r_div    <= (sif.cfg_div == '0) ? CNT_W'(1) : sif.cfg_div;
            r_hold   <= sif.cfg_hold;
        end
    end

    assign sif.duty_cycle = r_duty;
    assign sif.period     = r_period;
    assign sif.busy       = r_busy;
    assign sif.done       = r_done;

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Scoreboard bench for pwm_fade_sequencer (single-shot build).
// Expected output changes are queued per profile; a monitor pops them.
module tb_pwm_fade_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pwm_fade_sequencer_if #(.WIDTH(16), .CNT_W(16)) sif ();

    pwm_fade_sequencer #(.WIDTH(16), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .sif (sif)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int duty;
        bit busy;
        bit done;
        bit at_pulse;
        bit chk_per;
        int per;
    } ev_t;

    ev_t q[$];
    int  tests = 0;
    int  fails = 0;
    int  pcnt  = 0;
    int  cyc   = 0;
    int  lpc   = -1;
    int  l_duty;
    bit  l_busy;
    bit  l_done;

    task automatic chk(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void push_ev(int idx, int duty, bit busy, bit done,
                                    bit ap, bit cp, int per);
        ev_t e;
        if (!cp && duty == l_duty && busy == l_busy && done == l_done)
            return;
        e.idx = idx; e.duty = duty; e.busy = busy; e.done = done;
        e.at_pulse = ap; e.chk_per = cp; e.per = per;
        q.push_back(e);
        l_duty = duty; l_busy = busy; l_done = done;
    endfunction

    // Profile as a list of ticks: tick t lands on pulse base + t*div.
    function automatic void model(int base, int per, int cmin, int cmax,
                                  int step, int div, int hold);
        int mx, mn, st, dv, t, d;
        mx = (cmax < per) ? cmax : per;
        mn = (cmin < mx) ? cmin : mx;
        st = (step == 0) ? 1 : step;
        dv = (div == 0) ? 1 : div;
        push_ev(base, mn, 1, 0, 0, 1, per);
        t = 0;
        d = mn;
        while (1) begin
            t++;
            d = (d + st < mx) ? d + st : mx;
            push_ev(base + t * dv, d, 1, 0, 1, 0, 0);
            if (d >= mx) break;
        end
        t += hold;
        while (1) begin
            t++;
            d = (d >= mn + st) ? d - st : mn;
            if (d == mn) break;
            push_ev(base + t * dv, d, 1, 0, 1, 0, 0);
        end
        if (hold > 0) begin
            push_ev(base + t * dv, mn, 1, 0, 1, 0, 0);
            t += hold;
        end
        push_ev(base + t * dv, mn, 0, 1, 1, 0, 0);
        push_ev(base + t * dv, mn, 0, 0, 0, 0, 0);
    endfunction

    initial begin : counter
        forever begin
            @(posedge clk);
            cyc++;
            if (sif.pwm_period_end) begin
                pcnt++;
                lpc = cyc;
            end
        end
    end

    initial begin : monitor
        int  pd;
        bit  pb;
        bit  pdn;
        bit  ok;
        ev_t e;
        pd = 0; pb = 0; pdn = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (sif.done) begin
                    tests++;
                    if (pdn) begin
                        fails++;
                        $display("FAIL done_width: done high 2 clks at cyc %0d", cyc);
                    end
                end
                if (int'(sif.duty_cycle) != pd || sif.busy != pb || sif.done != pdn) begin
                    tests++;
                    if (q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_change: duty=%0d busy=%0d done=%0d pulse=%0d",
                                 sif.duty_cycle, sif.busy, sif.done, pcnt);
                    end else begin
                        e = q.pop_front();
                        ok = (e.duty == int'(sif.duty_cycle)) && (e.busy == sif.busy) &&
                             (e.done == sif.done) && (e.idx == pcnt) &&
                             (!e.at_pulse || lpc == cyc) &&
                             (!e.chk_per || e.per == int'(sif.period));
                        if (!ok) begin
                            fails++;
                            $display("FAIL output_event: got duty=%0d busy=%0d done=%0d per=%0d pulse=%0d lat=%0d, expected duty=%0d busy=%0d done=%0d per=%0d pulse=%0d",
                                     sif.duty_cycle, sif.busy, sif.done, sif.period, pcnt,
                                     cyc - lpc, e.duty, e.busy, e.done, e.per, e.idx);
                        end
                    end
                end
            end
            pd  = int'(sif.duty_cycle);
            pb  = sif.busy;
            pdn = sif.done;
        end
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic pulse();
        @(posedge clk);
        #1 sif.pwm_period_end = 1'b1;
        @(posedge clk);
        #1 sif.pwm_period_end = 1'b0;
        repeat ($urandom_range(0, 3)) @(posedge clk);
    endtask

    task automatic scramble_cfg();
        sif.cfg_period = 16'($urandom_range(0, 200));
        sif.cfg_min    = 16'($urandom_range(0, 200));
        sif.cfg_max    = 16'($urandom_range(0, 200));
        sif.cfg_step   = 16'($urandom_range(0, 50));
        sif.cfg_div    = 16'($urandom_range(0, 5));
        sif.cfg_hold   = 16'($urandom_range(0, 5));
    endtask

    task automatic launch(int per, int mn, int mx, int st, int dv, int hd);
        @(posedge clk);
        #1;
        sif.cfg_period = 16'(per);
        sif.cfg_min    = 16'(mn);
        sif.cfg_max    = 16'(mx);
        sif.cfg_step   = 16'(st);
        sif.cfg_div    = 16'(dv);
        sif.cfg_hold   = 16'(hd);
        sif.start      = 1'b1;
        model(pcnt, per, mn, mx, st, dv, hd);
        @(posedge clk);
        #1 sif.start = 1'b0;
        scramble_cfg();
    endtask

    task automatic do_abort();
        ev_t e;
        repeat (2) @(posedge clk);
        #1;
        q.delete();
        e.idx = pcnt + 1; e.duty = 0; e.busy = 0; e.done = 0;
        e.at_pulse = 1; e.chk_per = 0; e.per = 0;
        q.push_back(e);
        sif.abort          = 1'b1;
        sif.pwm_period_end = 1'b1;
        sif.start          = 1'b1;
        @(posedge clk);
        #1;
        sif.abort          = 1'b0;
        sif.pwm_period_end = 1'b0;
        sif.start          = 1'b0;
    endtask

    task automatic run_profile(int per, int mn, int mx, int st, int dv,
                               int hd, int abort_at);
        int n;
        launch(per, mn, mx, st, dv, hd);
        n = 0;
        while (sif.busy && n < 4000) begin
            if (abort_at > 0 && n == abort_at) begin
                do_abort();
                break;
            end
            if ($urandom_range(0, 7) == 0) begin
                scramble_cfg();
                sif.start = 1'b1;
                @(posedge clk);
                #1 sif.start = 1'b0;
            end
            pulse();
            n++;
        end
        if (n >= 4000) chk("profile_timeout", n, 0);
        repeat (4) @(posedge clk);
        #1 chk("queue_drained", q.size(), 0);
    endtask

    initial begin : stim
        sif.start          = 1'b0;
        sif.abort          = 1'b0;
        sif.pwm_period_end = 1'b0;
        sif.cfg_period     = '0;
        sif.cfg_min        = '0;
        sif.cfg_max        = '0;
        sif.cfg_step       = '0;
        sif.cfg_div        = '0;
        sif.cfg_hold       = '0;
        l_duty = 0; l_busy = 0; l_done = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_duty", int'(sif.duty_cycle), 0);
        chk("reset_period", int'(sif.period), 0);
        chk("reset_busy", int'(sif.busy), 0);
        chk("reset_done", int'(sif.done), 0);
        rst = 1'b0;

        // Asynchronous reset in the middle of a ramp-up
        launch(100, 10, 30, 10, 1, 0);
        pulse();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        q.delete();
        #1;
        chk("midrst_duty", int'(sif.duty_cycle), 0);
        chk("midrst_period", int'(sif.period), 0);
        chk("midrst_busy", int'(sif.busy), 0);
        chk("midrst_done", int'(sif.done), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        l_duty = 0; l_busy = 0; l_done = 0;

        run_profile(100, 10, 30, 10, 1, 0, 0);
        chk("final_duty", int'(sif.duty_cycle), 10);
        chk("final_busy", int'(sif.busy), 0);
        run_profile(100, 0, 95, 20, 1, 0, 0);
        run_profile(100, 10, 30, 10, 3, 2, 0);
        run_profile(50, 20, 20, 5, 0, 1, 0);
        run_profile(40, 60, 90, 0, 2, 0, 0);
        run_profile(100, 10, 30, 10, 1, 0, 3);
        chk("abort_period_kept_busy", int'(sif.busy), 0);

        for (int i = 0; i < 14; i++) begin
            int ab;
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : 0;
            run_profile($urandom_range(1, 60), $urandom_range(0, 40),
                        $urandom_range(0, 70),
                        ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 20),
                        $urandom_range(0, 3), $urandom_range(0, 3), ab);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
